ripple_adder_4bit: RTL and testbench
====================================

// Module: ripple_adder_4bit
//
// PURPOSE
//   Unsigned WIDTH-bit (default 4) ripple-carry adder built structurally from a chain of 1-bit full adders.
//   Computes {carry_out, sum} = a + b + carry_in combinationally with zero latency.
//   Also provides a registered copy of the result and a signed-overflow flag for clocked consumers.
//   Leaf arithmetic block; used standalone or as the slice of wider datapath adders.
//
// PARAMETERS
//   WIDTH  4  operand/sum width in bits; WIDTH >= 1; chain length = WIDTH full adders
//
// PORTS
//   clk          in   1      single clock; rising edge samples the registered outputs
//   rst_n        in   1      asynchronous, active-low reset
//   a            in   WIDTH  operand A, unsigned
//   b            in   WIDTH  operand B, unsigned
//   carry_in     in   1      carry into bit 0
//   sum          out  WIDTH  combinational sum, (a + b + carry_in) mod 2^WIDTH
//   carry_out    out  1      combinational carry out of bit WIDTH-1
//   overflow     out  1      combinational two's-complement overflow = c[WIDTH] ^ c[WIDTH-1]
//   sum_q        out  WIDTH  sum registered on the rising edge of clk
//   carry_out_q  out  1      carry_out registered on the rising edge of clk
//   overflow_q   out  1      overflow registered on the rising edge of clk
//
// BEHAVIOUR
//   - Carry chain: c[0] = carry_in. For each bit i:
//       sum[i]  = a[i] ^ b[i] ^ c[i]
//       c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
//     carry_out = c[WIDTH].
//   - Result identity: {carry_out, sum} == a + b + carry_in, exact with no truncation, over WIDTH+1 bits.
//   - Combinational outputs: sum, carry_out and overflow.
//     - No clock dependency and zero latency.
//     - Valid after the ripple settles on any input change.
//     - Unaffected by rst_n.
//   - Registered outputs: sum_q, carry_out_q and overflow_q.
//     - Latency of one cycle: on each rising clk edge they capture the current combinational values.
//     - No enable: they update every cycle.
//   - Reset: when rst_n goes low, sum_q = 0, carry_out_q = 0 and overflow_q = 0 immediately.
//     - This is asynchronous and does not wait for a clk edge.
//     - Reset is released synchronously to the design; the first capture occurs on the first rising clk edge with rst_n = 1.
//   - Reset asserted mid-operation: the registered outputs clear at once; the combinational outputs keep tracking the inputs.
//   - Boundaries:
//     - Maximum operands: a = b = 2^WIDTH-1 with carry_in = 1 gives sum = all-ones and carry_out = 1.
//     - Wrap-around: all-ones + 0 + 1 gives sum = 0 and carry_out = 1.
//   - X-propagation: an X/Z input bit propagates X to the affected sum bits and to all higher carries. No masking is applied.
//   - No latches. All combinational logic is fully specified.
//
// STRUCTURE
//   - Sub-module full_adder (a, b, cin -> s, cout) implements the per-bit equations above.
//     - WIDTH instances are generated and chained through the internal bus c[WIDTH:0].
//   - Registered outputs sit in one always block sensitive to posedge clk or negedge rst_n.
//   - No shared package is required.
//     - If the datapath package exists, it may hold a localparam default width (4).
//     - The block has no typedefs.
//
// TESTING
//   1. a=0, b=0, carry_in=0 -> sum=0, carry_out=0. Then carry_in=1 -> sum=1, carry_out=0.
//   2. a=1, b=1, carry_in=0 -> sum=2, carry_out=0. Then carry_in=1 -> sum=3, carry_out=0.
//   3. a=3, b=6, carry_in=0 -> sum=9, carry_out=0, overflow=1 (signed 3 + 6 overflows in 4 bits).
//   4. Boundary cases:
//      - a=15, b=1, carry_in=0 -> sum=0, carry_out=1.
//      - a=15, b=15, carry_in=1 -> sum=15, carry_out=1.
//      - a=7, b=1 -> sum=8, overflow=1.
//   5. Exhaustive sweep of a, b in 0..15 and carry_in in 0..1 (512 vectors):
//      - check {carry_out, sum} == a + b + carry_in;
//      - check overflow against the signed-result reference.
//   6. Registered path:
//      - rst_n=0 -> sum_q, carry_out_q and overflow_q are 0 without any clk edge.
//      - Release rst_n, apply a=9, b=8 -> one clk edge later sum_q=1, carry_out_q=1.
//      - Assert rst_n mid-run -> registered outputs clear immediately; sum still shows 1.

Source files
------------

// File: rtl/ripple_adder_4bit_pkg.sv
// Shared constants for the ripple adder slice.
package ripple_adder_4bit_pkg;
  localparam int RA_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/ripple_adder_4bit_full_adder.sv
// One-bit full adder: the per-bit link of the ripple carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/ripple_adder_4bit.sv
// WIDTH-bit ripple-carry adder with combinational result, overflow flag and a
// registered copy of all three for clocked consumers.
module ripple_adder_4bit
  import ripple_adder_4bit_pkg::*;
#(
  parameter int WIDTH = RA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_out_d;
  logic             overflow_d;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign carry_out_d = c[WIDTH];
  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  assign overflow_d  = c[WIDTH] ^ c[WIDTH-1];

  assign sum       = sum_d;
  assign carry_out = carry_out_d;
  assign overflow  = overflow_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end
endmodule

// File: tb/tb_ripple_adder_4bit.sv
// Directed and exhaustive checks of the 4-bit ripple adder, combinational and registered paths.
module tb_ripple_adder_4bit;
  logic       clk;
  logic       rst_n;
  logic [3:0] a, b;
  logic       carry_in;
  logic [3:0] sum, sum_q;
  logic       carry_out, overflow, carry_out_q, overflow_q;

  int n_run  = 0;
  int n_fail = 0;

  ripple_adder_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q),
    .overflow_q  (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic ci);
    a = av; b = bv; carry_in = ci;
    #1;
  endtask

  // Directed vectors: a, b, cin, expected sum, carry_out, overflow
  typedef struct {
    logic [3:0] a, b;
    logic       ci;
    logic [3:0] s;
    logic       co, ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0};
    vecs[1] = '{4'd0,  4'd0,  1'b1, 4'd1,  1'b0, 1'b0};
    vecs[2] = '{4'd1,  4'd1,  1'b0, 4'd2,  1'b0, 1'b0};
    vecs[3] = '{4'd1,  4'd1,  1'b1, 4'd3,  1'b0, 1'b0};
    vecs[4] = '{4'd3,  4'd6,  1'b0, 4'd9,  1'b0, 1'b1};
    vecs[5] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1, 1'b0};
    vecs[6] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0};
    vecs[7] = '{4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};

    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0);
    chk("rst_sum_q", 32'(sum_q), 32'd0);
    chk("rst_co_q",  32'(carry_out_q), 32'd0);
    chk("rst_ov_q",  32'(overflow_q), 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].ci);
      chk($sformatf("dir%0d_sum", i), 32'(sum), 32'(vecs[i].s));
      chk($sformatf("dir%0d_co", i),  32'(carry_out), 32'(vecs[i].co));
      chk($sformatf("dir%0d_ov", i),  32'(overflow), 32'(vecs[i].ov));
    end

    // wrap-around boundary
    drive(4'd15, 4'd0, 1'b1);
    chk("wrap_sum", 32'(sum), 32'd0);
    chk("wrap_co",  32'(carry_out), 32'd1);

    // registers must stay cleared while reset is held across clock edges
    @(posedge clk); #1;
    chk("rst_hold_sum_q", 32'(sum_q), 32'd0);
    chk("rst_hold_co_q",  32'(carry_out_q), 32'd0);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          int sa, sb, sr, tot;
          logic ov_ref;
          drive(4'(ai), 4'(bi), 1'(ci));
          tot = ai + bi + ci;
          sa  = (ai >= 8) ? ai - 16 : ai;
          sb  = (bi >= 8) ? bi - 16 : bi;
          sr  = sa + sb + ci;
          ov_ref = (sr > 7) || (sr < -8);
          chk($sformatf("sw_%0d_%0d_%0d", ai, bi, ci), 32'({carry_out, sum}), 32'(tot));
          chk($sformatf("sw_ov_%0d_%0d_%0d", ai, bi, ci), 32'(overflow), 32'(ov_ref));
        end

    // registered path
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd9, 4'd8, 1'b0);
    @(posedge clk); #1;
    chk("reg_sum_q", 32'(sum_q), 32'd1);
    chk("reg_co_q",  32'(carry_out_q), 32'd1);
    chk("reg_ov_q",  32'(overflow_q), 32'd1);

    drive(4'd2, 4'd3, 1'b0);
    chk("reg_lat_sum_q", 32'(sum_q), 32'd1);
    @(posedge clk); #1;
    chk("reg_upd_sum_q", 32'(sum_q), 32'd5);
    chk("reg_upd_co_q",  32'(carry_out_q), 32'd0);
    chk("reg_upd_ov_q",  32'(overflow_q), 32'd0);

    drive(4'd9, 4'd8, 1'b0);
    @(posedge clk); #2;
    chk("pre_rst_sum_q", 32'(sum_q), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum_q", 32'(sum_q), 32'd0);
    chk("mid_rst_co_q",  32'(carry_out_q), 32'd0);
    chk("mid_rst_ov_q",  32'(overflow_q), 32'd0);
    chk("mid_rst_sum",   32'(sum), 32'd1);
    chk("mid_rst_co",    32'(carry_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
